// File: rtl/bin2gcode_conv_pkg.sv
// Shared definitions for the codes utility area: default code width, code word
// type and generic binary/Gray conversion helpers.
package bin2gcode_conv_pkg;

  localparam int unsigned WidthDefault = 4;
  // Widest code word the helper functions handle; narrower words are zero-extended.
  localparam int unsigned MaxWidth = 64;

  typedef logic [WidthDefault-1:0] code_t;
  typedef logic [MaxWidth-1:0]     wide_code_t;

  // Reflected-binary encode; zero-extension leaves the result unaffected.
  function automatic wide_code_t bin2gray(input wide_code_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray decode as a prefix XOR from the MSB downward.
  function automatic wide_code_t gray2bin(input wide_code_t gray);
    wide_code_t bin;
    bin[MaxWidth-1] = gray[MaxWidth-1];
    for (int i = int'(MaxWidth) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/bin2gcode_conv_gcode2bin_dec.sv
// Combinational Gray-to-binary decoder, reusable across the codes area.
module gcode2bin_dec
  import bin2gcode_conv_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/bin2gcode_conv.sv
// Binary to reflected-binary Gray converter with a combinational output and a
// registered copy. Define BIN2GCODE_CHECK_EN to add a self-check that decodes
// the Gray output back and flags any disagreement on chk_err.
module bin2gcode_conv
  import bin2gcode_conv_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
`ifdef BIN2GCODE_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  // Zero-latency conversion; logical shift zero-fills the MSB.
  assign out = in_ ^ (in_ >> 1);

  // Registered copy of the Gray code, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

`ifdef BIN2GCODE_CHECK_EN
  logic [WIDTH-1:0] dec_bin;

  gcode2bin_dec #(
    .WIDTH (WIDTH)
  ) u_dec (
    .gray (out),
    .bin  (dec_bin)
  );

  // Flag a round-trip mismatch between the decoded Gray code and the input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_err <= 1'b0;
    end else begin
      chk_err <= (dec_bin != in_);
    end
  end
`endif

endmodule

// File: tb/tb_bin2gcode_conv.sv
// Self-checking bench for bin2gcode_conv (WIDTH=4): exhaustive sweep against
// the reference mapping, adjacency, registered path via scoreboard, async reset.
module tb_bin2gcode_conv;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
`ifdef BIN2GCODE_CHECK_EN
  logic         chk_err;
`endif

  int vectors;
  int miscompares;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] gray_map [16];

  bin2gcode_conv #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in_   (in_),
    .out   (out),
    .out_q (out_q)
`ifdef BIN2GCODE_CHECK_EN
    ,
    .chk_err (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [W-1:0] prev_out;
    logic [W-1:0] exp_val;
    int           seq [17];

    vectors     = 0;
    miscompares = 0;
    gray_map = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    for (int i = 0; i < 16; i++) seq[i] = i;
    seq[16] = 0;  // wrap 1111 -> 0000

    // Reset phase: out_q held at zero, out still tracks in_.
    reset = 1'b0;
    in_   = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_q", 32'(out_q), 32'h0);
    check("rst_out", 32'(out), 32'(4'b1111));
`ifdef BIN2GCODE_CHECK_EN
    check("rst_chk_err", 32'(chk_err), 32'h0);
`endif

    @(negedge clk);
    reset = 1'b1;
    prev_out = '0;

    // Sweep: drive on negedge, combinational check at once, registered check
    // after the following rising edge via the scoreboard.
    for (int i = 0; i < 17; i++) begin
      in_ = W'(seq[i]);
      #1;
      check($sformatf("comb_%0d", seq[i]), 32'(out), 32'(gray_map[seq[i]]));
      if (i > 0) begin
        check($sformatf("adj_%0d", seq[i]), $countones(out ^ prev_out), 32'd1);
      end
      prev_out = out;
      exp_q.push_back(gray_map[seq[i]]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'h1, 32'h0);
      end else begin
        exp_val = exp_q.pop_front();
        check($sformatf("reg_%0d", seq[i]), 32'(out_q), 32'(exp_val));
      end
`ifdef BIN2GCODE_CHECK_EN
      check($sformatf("chk_err_%0d", seq[i]), 32'(chk_err), 32'h0);
`endif
      @(negedge clk);
    end

    // Async reset mid-run: out_q clears between edges, out keeps tracking.
    in_ = 4'b1111;
    @(posedge clk);
    #1;
    check("pre_rst_out_q", 32'(out_q), 32'(4'b1000));
    #2;
    reset = 1'b0;
    #1;
    check("async_out_q", 32'(out_q), 32'h0);
    check("async_out", 32'(out), 32'(4'b1000));
    @(posedge clk);
    #1;
    check("hold_out_q", 32'(out_q), 32'h0);
`ifdef BIN2GCODE_CHECK_EN
    check("hold_chk_err", 32'(chk_err), 32'h0);
`endif

    // Release and confirm first capture on the next rising edge.
    @(negedge clk);
    reset = 1'b1;
    in_   = 4'b0101;
    #1;
    check("rel_out", 32'(out), 32'(4'b0111));
    check("rel_out_q_before", 32'(out_q), 32'h0);
    @(posedge clk);
    #1;
    check("rel_out_q", 32'(out_q), 32'(4'b0111));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
